// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a DEPTH-word register array, with a fixed number of
// wait states, pslverr on out-of-range word addresses and a protocol-error pulse.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [WIDTH-1:0]      pwdata_i,
    output logic [WIDTH-1:0]      prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic                  proto_err_o
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [4:0]            WAIT_L  = 5'(WAIT_CYCLES);

    state_t                state, state_d;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]      prdata_d;
    logic                  pready_d, pslverr_d, proto_err_d;
    logic                  mem_we, do_setup, load_done;

    logic                  load_setup;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic                  src_write;
    logic                  src_oor;
    logic [WIDTH-1:0]      src_word;

    // A setup phase samples the live bus; any other completion uses the latched transfer.
    assign load_setup = psel_i && !penable_i;
    assign src_addr   = load_setup ? paddr_i : addr_q;
    assign src_write  = load_setup ? pwrite_i : write_q;
    assign src_oor    = ({1'b0, src_addr} >= DEPTH_L);
    assign src_word   = mem[src_addr[IDX_W-1:0]];

    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        prdata_d    = prdata_o;
        pready_d    = pready_o;
        pslverr_d   = pslverr_o;
        proto_err_d = 1'b0;
        mem_we      = 1'b0;
        do_setup    = 1'b0;
        load_done   = 1'b0;

        case (state)
            IDLE: begin
                if (load_setup) begin
                    do_setup = 1'b1;
                end else if (penable_i) begin
                    proto_err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel_i || !penable_i) begin
                    proto_err_d = 1'b1;
                    pready_d    = 1'b0;
                    pslverr_d   = 1'b0;
                    state_d     = IDLE;
                    do_setup    = load_setup;
                end else if (pready_o) begin
                    mem_we    = write_q && !src_oor;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d     = cnt_q + 4'd1;
                    load_done = (({1'b0, cnt_q} + 5'd1) == WAIT_L);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_setup) begin
            addr_d    = paddr_i;
            write_d   = pwrite_i;
            wdata_d   = pwdata_i;
            cnt_d     = 4'd0;
            state_d   = ACCESS;
            load_done = (WAIT_CYCLES == 0);
        end

        if (load_done) begin
            pready_d  = 1'b1;
            pslverr_d = src_oor;
            if (!src_write) begin
                prdata_d = src_oor ? '0 : src_word;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            prdata_o    <= '0;
            pready_o    <= 1'b0;
            pslverr_o   <= 1'b0;
            proto_err_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            prdata_o    <= prdata_d;
            pready_o    <= pready_d;
            pslverr_o   <= pslverr_d;
            proto_err_o <= proto_err_d;
            if (mem_we) begin
                mem[addr_q[IDX_W-1:0]] <= wdata_q;
            end
        end
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB3 completer (slave) that consumes the psel/penable/pwrite/paddr/pwdata signals driven by the testbench BFM, and returns prdata/pready/pslverr. It is the DUT that the driver and monitor clocking blocks attach to. Storage is a DEPTH-word register array. The block inserts a configurable number of wait states and flags out-of-range accesses with pslverr.

Parameters:
ADDR_WIDTH, 8, width of paddr_i; paddr_i is a word index, not a byte address.
WIDTH, 32, data width of pwdata_i, prdata_o and each memory word.
DEPTH, 64, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
WAIT_CYCLES, 2, number of access-phase cycles with pready_o low before completion (0..15).

Ports:
pclk_i  input  1  clock; all logic on rising edge.
preset_i  input  1  synchronous, active-high reset.
psel_i  input  1  slave select.
penable_i  input  1  access-phase strobe.
pwrite_i  input  1  1 = write, 0 = read.
paddr_i  input  ADDR_WIDTH  word address.
pwdata_i  input  WIDTH  write data.
prdata_o  output  WIDTH  read data, registered.
pready_o  output  1  transfer-complete strobe, registered.
pslverr_o  output  1  error response, registered; valid only while pready_o=1.
proto_err_o  output  1  one-cycle pulse on an APB protocol violation.

Behaviour:
- Reset (preset_i=1 at an edge): state=IDLE, all memory words=0, prdata_o=0, pready_o=0, pslverr_o=0, proto_err_o=0, wait counter=0. Reset overrides everything, including an in-flight transfer.
- State IDLE:
  - Edge with psel_i=1 and penable_i=0 (setup phase): latch paddr_i, pwrite_i and pwdata_i; clear cnt to 0; go to ACCESS.
  - If WAIT_CYCLES==0, completion outputs (below) are also loaded at this edge, so pready_o=1 in the first access cycle.
  - Edge with penable_i=1 while in IDLE: ignored, no state change; proto_err_o=1 for one cycle.
- State ACCESS:
  - Only the latched address, direction and data are used; changes on the bus during ACCESS do not affect the transfer.
  - Edge with psel_i=1, penable_i=1, pready_o=0: cnt increments. When cnt+1==WAIT_CYCLES, load completion outputs.
  - Result: exactly WAIT_CYCLES access cycles show pready_o=0.
- Completion outputs: pready_o=1. pslverr_o = (latched addr >= DEPTH).
  - Read: prdata_o = mem[addr] if in range, else 0.
  - Write: prdata_o holds its previous value.
- Completing edge (psel_i=1, penable_i=1, pready_o=1):
  - If write and in range, mem[addr] <= latched pwdata.
  - Out-of-range writes are dropped.
  - pready_o<=0, pslverr_o<=0, go to IDLE.
  - prdata_o holds until the next read completes.
- Back-to-back transfers: the next setup phase is sampled in the cycle after completion (IDLE), giving minimum throughput of one transfer per 2+WAIT_CYCLES cycles.
- Abort: edge in ACCESS with psel_i=0, or with penable_i=0 while psel_i=1:
  - No memory write; pready_o<=0, pslverr_o<=0; proto_err_o=1 for one cycle; go to IDLE.
  - If the abort condition is psel_i=1 and penable_i=0, it is also treated as a new setup: latch and go to ACCESS.
- proto_err_o is 0 in every cycle not listed above.
- Reset mid-ACCESS: the transfer is discarded, memory is cleared, and outputs are 0 in the following cycle.

Test Plan:
- Reset, then write 0xDEAD_BEEF to addr 5, then read addr 5 (WAIT_CYCLES=2) -> each transfer shows 2 cycles of pready_o=0 then 1 cycle of pready_o=1; read returns prdata_o=0xDEAD_BEEF; pslverr_o=0.
- Read addr 70 and write 0x1234 to addr 64 (DEPTH=64) -> pslverr_o=1 with pready_o; read prdata_o=0; memory contents unchanged (spot-check addr 0 and addr 63 still read 0 after reset).
- WAIT_CYCLES=0: write 0xA5 to addr 0 then read addr 0 -> pready_o=1 in the first access cycle; each transfer takes exactly 2 cycles; read returns 0xA5.
- Drop psel_i in the second access cycle of a write of 0x77 to addr 3 -> proto_err_o pulses for 1 cycle; a subsequent read of addr 3 returns 0; a normal transfer afterwards completes correctly.
- penable_i=1 with psel_i=1 while in IDLE, with no prior setup -> proto_err_o pulses; no pready_o; state stays IDLE.
- Assert preset_i during ACCESS of a write of 0xFF to addr 2 -> the next cycle shows all outputs 0; a read of addr 2 returns 0.
